// File: rtl/dpsk_diff_demod_if.sv
`default_nettype none
// ============================================================================
//  Module      : dpsk_diff_demod_if
//  Description : Line-sample / decision bundle of the differential DPSK receiver.
//  Revision    : 1.0  initial release
// ============================================================================
interface dpsk_diff_demod_if;
   logic x;
   logic y;
   logic valid;
   logic erase;

   // master = line source and decision consumer, slave = demodulator
   modport master (output x, input y, input valid, input erase);
   modport slave  (input x, output y, output valid, output erase);
endinterface
`default_nettype wire

// File: rtl/dpsk_diff_demod.sv
`default_nettype none
// ============================================================================
//  Module      : dpsk_diff_demod
//  Description : Phase-comparison DPSK receiver: XOR with the previous symbol,
//                integrate mismatches, majority decision at symbol end.
//                Optional erasure flag: define DPSK_DEMOD_ERASE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module dpsk_diff_demod #(
   parameter int SYM_LEN = 8,
   parameter int MARGIN  = 1
) (
   input  logic                 clk,
   input  logic                 start,
   dpsk_diff_demod_if.slave     bus
);

   localparam int c_kw = $clog2(SYM_LEN);
   localparam int c_aw = $clog2(SYM_LEN + 1);
   localparam logic [c_kw-1:0] c_last = c_kw'(SYM_LEN - 1);
   localparam logic [c_aw-1:0] c_half = c_aw'(SYM_LEN / 2);

   typedef enum logic [0:0] {
      ST_FIRST = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   if ((SYM_LEN < 4) || ((SYM_LEN % 2) != 0) || (MARGIN < 0) || (MARGIN > SYM_LEN / 2)) begin : g_bad_cfg
      $error("dpsk_diff_demod: unsupported SYM_LEN/MARGIN combination");
   end

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_kw-1:0]    r_k;
   logic [SYM_LEN-1:0] r_dly;
   logic [c_aw-1:0]    r_acc;
   logic               r_y;
   logic               r_valid;
   logic               r_erase;

   logic               w_d;
   logic               w_m;
   logic [c_aw-1:0]    w_tot;
   logic               w_sym_end;
   logic               w_dec;
   logic               w_erase_dec;
   logic               w_y_nxt;
   logic               w_valid_nxt;
   logic               w_erase_nxt;

   assign w_d       = r_dly[SYM_LEN-1];
   assign w_m       = bus.x ^ w_d;
   assign w_tot     = r_acc + {{(c_aw-1){1'b0}}, w_m};
   assign w_sym_end = (r_k == c_last);
   assign w_dec     = (w_tot > c_half);

`ifdef DPSK_DEMOD_ERASE_EN
   localparam int c_lo_i = SYM_LEN / 2 - MARGIN;
   localparam int c_hi_i = SYM_LEN / 2 + MARGIN;
   localparam logic [c_aw-1:0] c_lo = c_aw'(c_lo_i);
   localparam logic [c_aw-1:0] c_hi = c_aw'(c_hi_i);

   assign w_erase_dec = (w_tot >= c_lo) && (w_tot <= c_hi);
`else
   assign w_erase_dec = 1'b0;
`endif

   // Symbol timing, reference delay line and mismatch integrator
   always_ff @(posedge clk or negedge start) begin
      if (!start) begin
         r_k   <= '0;
         r_dly <= '0;
         r_acc <= '0;
      end else begin
         r_k   <= w_sym_end ? '0 : r_k + 1'b1;
         r_dly <= {r_dly[SYM_LEN-2:0], bus.x};
         r_acc <= w_sym_end ? '0 : w_tot;
      end
   end

   always_ff @(posedge clk or negedge start) begin
      if (!start) begin
         r_state <= ST_FIRST;
         r_y     <= 1'b0;
         r_valid <= 1'b0;
         r_erase <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_y     <= w_y_nxt;
         r_valid <= w_valid_nxt;
         r_erase <= w_erase_nxt;
      end
   end

   // The first symbol after reset is compared against the zeroed delay line,
   // so its decision is thrown away.
   always_comb begin
      w_state_nxt = r_state;
      w_y_nxt     = r_y;
      w_valid_nxt = 1'b0;
      w_erase_nxt = 1'b0;
      if (w_sym_end) begin
         case (r_state)
            ST_FIRST: begin
               w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
               w_valid_nxt = 1'b1;
               w_y_nxt     = w_dec;
               w_erase_nxt = w_erase_dec;
            end
            default: begin
               w_state_nxt = ST_FIRST;
            end
         endcase
      end
   end

   assign bus.y     = r_y;
   assign bus.valid = r_valid;
   assign bus.erase = r_erase;

endmodule
`default_nettype wire

// File: tb/tb_dpsk_diff_demod.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dpsk_diff_demod
//  Description : Randomized self-checking bench for dpsk_diff_demod against a
//                sample-history reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dpsk_diff_demod;

   localparam int c_sym    = 8;
   localparam int c_margin = 1;
`ifdef DPSK_DEMOD_ERASE_EN
   localparam bit c_erase_en = 1'b1;
`else
   localparam bit c_erase_en = 1'b0;
`endif
   localparam logic [7:0] c_carrier = 8'hF0;

   logic clk;
   logic start;

   dpsk_diff_demod_if bus ();

   dpsk_diff_demod #(
      .SYM_LEN (c_sym),
      .MARGIN  (c_margin)
   ) u_dut (
      .clk   (clk),
      .start (start),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;
   bit hist[$];
   bit ph[$];
   int n_smp;
   int last_v;
   bit exp_y;
   bit phase_mode;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (sample %0d)", tag, got, exp, n_smp);
      end
   endtask

   // Mismatch count between completed symbol s and symbol s-1
   function automatic int sym_tot(input int s);
      int t = 0;
      for (int j = 0; j < c_sym; j++)
         t += (hist[s*c_sym + j] != hist[(s-1)*c_sym + j]) ? 1 : 0;
      return t;
   endfunction

   task automatic check_outputs();
      bit exp_v;
      bit exp_e;
      int s;
      int tot;
      exp_v = ((n_smp % c_sym) == 0) && (n_smp >= 2*c_sym);
      exp_e = 1'b0;
      if (exp_v) begin
         s     = n_smp / c_sym - 1;
         tot   = sym_tot(s);
         exp_y = (tot > c_sym/2);
         exp_e = c_erase_en && (tot >= c_sym/2 - c_margin) && (tot <= c_sym/2 + c_margin);
         if (last_v < 0)
            check("first_valid_at", n_smp, 2*c_sym);
         else
            check("valid_gap", n_smp - last_v, c_sym);
         last_v = n_smp;
         if (phase_mode)
            check("phase_xor", int'(bus.y), int'(ph[s] ^ ph[s-1]));
      end
      check("valid", int'(bus.valid), int'(exp_v));
      check("y", int'(bus.y), int'(exp_y));
      check("erase", int'(bus.erase), int'(exp_e));
   endtask

   task automatic step(input bit xv);
      bus.x = xv;
      @(posedge clk);
      #1;
      hist.push_back(xv);
      n_smp++;
      check_outputs();
   endtask

   task automatic send_sym(input logic [7:0] p);
      for (int j = c_sym - 1; j >= 0; j--)
         step(p[j]);
   endtask

   task automatic apply_reset(input int hold);
      start = 1'b0;
      #1;
      check("rst_y", int'(bus.y), 0);
      check("rst_valid", int'(bus.valid), 0);
      check("rst_erase", int'(bus.erase), 0);
      repeat (hold) @(posedge clk);
      #1;
      check("rst_hold_y", int'(bus.y), 0);
      check("rst_hold_valid", int'(bus.valid), 0);
      @(negedge clk);
      start = 1'b1;
      hist.delete();
      ph.delete();
      n_smp      = 0;
      last_v     = -1;
      exp_y      = 1'b0;
      phase_mode = 1'b0;
   endtask

   logic [7:0] masks[13] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00,
                             8'hF8, 8'h3C, 8'hFF, 8'h01, 8'h7F, 8'h00};

   initial begin
      logic [7:0] sym;
      bit         p;
      n_vec      = 0;
      n_err      = 0;
      n_smp      = 0;
      last_v     = -1;
      exp_y      = 1'b0;
      phase_mode = 1'b0;
      start      = 1'b0;
      bus.x      = 1'b0;
      #3;
      apply_reset(3);

      // Clean carrier, inversions, then mismatch totals 5, 4, 8, 1, 7
      sym = c_carrier;
      send_sym(sym);
      foreach (masks[i]) begin
         sym = sym ^ masks[i];
         send_sym(sym);
      end

      // Abort at k=5 of symbol 3
      apply_reset(2);
      for (int i = 0; i < 3; i++)
         send_sym(c_carrier);
      for (int j = 7; j >= 3; j--)
         step(c_carrier[j]);
      apply_reset(10);

      // Fully random line samples
      for (int i = 0; i < 30 * c_sym; i++)
         step(1'($urandom_range(0, 1)));

      // Long run of random phases on a clean carrier
      apply_reset(2);
      phase_mode = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         p = 1'($urandom_range(0, 1));
         ph.push_back(p);
         send_sym(p ? ~c_carrier : c_carrier);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
